bitrev_seq: RTL and testbench

BITREV_SEQ -- requirements
Module: bitrev_seq

---
 rtl/bitrev_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_bitrev_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_seq.sv
// bitrev_seq: register-mapped job controller feeding an external datapath.
// Words pushed into an input FIFO are streamed to the datapath for LEN
// words. Results are collected into an output FIFO that software pops.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   req_i/gnt_o           register request, always granted
//   addr_i/we_i/wdata_i   register access
//   rvalid_o/rdata_o/err_o  response, one cycle after the request
//   dp_in_*               word stream to the datapath (valid/ready)
//   dp_out_*              result stream from the datapath (valid/ready)
//   irq_o                 one-cycle pulse on normal job completion
module bitrev_seq #(
   parameter int DW    = 32,
   parameter int Depth = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_i,
   output logic          gnt_o,
   input  logic [4:0]    addr_i,
   input  logic          we_i,
   input  logic [31:0]   wdata_i,
   output logic          rvalid_o,
   output logic [31:0]   rdata_o,
   output logic          err_o,
   output logic          dp_in_valid_o,
   output logic [DW-1:0] dp_in_data_o,
   input  logic          dp_in_ready_i,
   input  logic          dp_out_valid_i,
   input  logic [DW-1:0] dp_out_data_i,
   output logic          dp_out_ready_o,
   output logic          irq_o
);

   localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CW = AW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;

   localparam logic [2:0] A_CTRL = 3'd0;
   localparam logic [2:0] A_STAT = 3'd1;
   localparam logic [2:0] A_DIN  = 3'd2;
   localparam logic [2:0] A_DOUT = 3'd3;
   localparam logic [2:0] A_LEN  = 3'd4;

   logic [1:0]    r_state;
   logic [7:0]    r_len;
   logic [7:0]    r_issued;
   logic [7:0]    r_ret;
   logic          r_done;
   logic          r_irq;
   logic          r_rvalid;
   logic          r_err;
   logic [31:0]   r_rdata;

   logic [DW-1:0] r_in_mem  [Depth];
   logic [DW-1:0] r_out_mem [Depth];
   logic [AW-1:0] r_in_wp, r_in_rp;
   logic [AW-1:0] r_out_wp, r_out_rp;
   logic [CW-1:0] r_in_cnt, r_out_cnt;

   logic [2:0]    w_off;
   logic          w_busy;
   logic          w_in_full, w_in_empty;
   logic          w_out_full, w_out_empty;
   logic          w_wr, w_rd;
   logic          w_ctrl_wr, w_start, w_clear;
   logic          w_push_in, w_pop_out, w_len_wr;
   logic          w_in_hs, w_out_hs, w_push_out;
   logic          w_err;
   logic [31:0]   w_rdata;
   logic          w_unused;

   assign w_off       = addr_i[4:2];
   assign w_busy      = (r_state != S_IDLE);
   assign w_in_full   = (r_in_cnt == CW'(Depth));
   assign w_in_empty  = (r_in_cnt == '0);
   assign w_out_full  = (r_out_cnt == CW'(Depth));
   assign w_out_empty = (r_out_cnt == '0);

   assign w_wr      = req_i & we_i;
   assign w_rd      = req_i & ~we_i;
   assign w_ctrl_wr = w_wr & (w_off == A_CTRL);
   // CLEAR has priority over START in the same write
   assign w_start   = w_ctrl_wr & wdata_i[0] & ~wdata_i[1];
   assign w_clear   = w_ctrl_wr & wdata_i[1];
   // full is judged on the registered count, before any same-cycle pop
   assign w_push_in = w_wr & (w_off == A_DIN) & ~w_in_full;
   assign w_pop_out = w_rd & (w_off == A_DOUT) & ~w_out_empty;
   assign w_len_wr  = w_wr & (w_off == A_LEN) & ~w_busy;

   assign w_in_hs    = dp_in_valid_o & dp_in_ready_i;
   assign w_out_hs   = dp_out_valid_i & dp_out_ready_o;
   assign w_push_out = w_out_hs & ((r_state == S_RUN) | (r_state == S_DRAIN));

   assign w_unused = ^{addr_i[1:0], wdata_i};

   assign gnt_o    = 1'b1;
   assign rvalid_o = r_rvalid;
   assign rdata_o  = r_rdata;
   assign err_o    = r_err;
   assign irq_o    = r_irq;

   // issued < LEN gate keeps valid stable: only the handshake can drop it
   assign dp_in_valid_o = (r_state == S_RUN) & ~w_in_empty & (r_issued < r_len);
   assign dp_in_data_o  = dp_in_valid_o ? r_in_mem[r_in_rp] : '0;

   always_comb begin
      dp_out_ready_o = 1'b0;
      case (r_state)
         S_RUN, S_DRAIN: dp_out_ready_o = ~w_out_full;
         S_FLUSH:        dp_out_ready_o = 1'b1;
         default:        dp_out_ready_o = 1'b0;
      endcase
   end

   always_comb begin
      w_err   = 1'b0;
      w_rdata = '0;
      case (w_off)
         A_CTRL: w_err = ~we_i;
         A_STAT: begin
            if (we_i) w_err = 1'b1;
            else w_rdata = {11'd0, 5'(r_out_cnt), 3'd0, 5'(r_in_cnt),
                            6'd0, r_done, w_busy};
         end
         A_DIN:  w_err = ~we_i | w_in_full;
         A_DOUT: begin
            if (we_i | w_out_empty) w_err = 1'b1;
            else w_rdata = 32'(r_out_mem[r_out_rp]);
         end
         A_LEN: begin
            if (we_i) w_err = w_busy;
            else w_rdata = {24'd0, r_len};
         end
         default: w_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= req_i;
         r_err    <= req_i & w_err;
         r_rdata  <= req_i ? w_rdata : '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_len    <= '0;
         r_issued <= '0;
         r_ret    <= '0;
         r_done   <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_irq <= 1'b0;
         if (w_len_wr) r_len <= wdata_i[7:0];
         if (w_in_hs) r_issued <= r_issued + 8'd1;
         if (w_out_hs && (r_ret != r_len)) r_ret <= r_ret + 8'd1;
         case (r_state)
            S_IDLE: begin
               if (w_clear) begin
                  r_done <= 1'b0;
               end else if (w_start && (r_len != 8'd0)) begin
                  r_state  <= S_RUN;
                  r_done   <= 1'b0;
                  r_issued <= '0;
                  r_ret    <= '0;
               end
            end
            S_RUN: begin
               if (w_clear) r_state <= S_FLUSH;
               else if (r_issued == r_len) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_clear) begin
                  r_state <= S_FLUSH;
               end else if (r_ret == r_len) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                  r_irq   <= 1'b1;
               end
            end
            default: begin
               if (r_ret == r_issued) r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_in_wp  <= '0;
         r_in_rp  <= '0;
         r_in_cnt <= '0;
      end else if (w_clear) begin
         r_in_wp  <= '0;
         r_in_rp  <= '0;
         r_in_cnt <= '0;
      end else begin
         if (w_push_in) r_in_wp <= r_in_wp + AW'(1);
         if (w_in_hs) r_in_rp <= r_in_rp + AW'(1);
         case ({w_push_in, w_in_hs})
            2'b10:   r_in_cnt <= r_in_cnt + CW'(1);
            2'b01:   r_in_cnt <= r_in_cnt - CW'(1);
            default: r_in_cnt <= r_in_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_out_wp  <= '0;
         r_out_rp  <= '0;
         r_out_cnt <= '0;
      end else if (w_clear) begin
         r_out_wp  <= '0;
         r_out_rp  <= '0;
         r_out_cnt <= '0;
      end else begin
         if (w_push_out) r_out_wp <= r_out_wp + AW'(1);
         if (w_pop_out) r_out_rp <= r_out_rp + AW'(1);
         case ({w_push_out, w_pop_out})
            2'b10:   r_out_cnt <= r_out_cnt + CW'(1);
            2'b01:   r_out_cnt <= r_out_cnt - CW'(1);
            default: r_out_cnt <= r_out_cnt;
         endcase
      end
   end

   // storage needs no reset: counts gate every read
   always_ff @(posedge clk_i) begin
      if (w_push_in) r_in_mem[r_in_wp] <= wdata_i[DW-1:0];
      if (w_push_out) r_out_mem[r_out_wp] <= dp_out_data_i;
   end

endmodule

// File: tb/tb_bitrev_seq.sv
// tb_bitrev_seq: directed bench for bitrev_seq with a bit-reversing
// datapath responder (latency 2, optional stall and hold controls).
module tb_bitrev_seq;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        gnt_o;
   logic [4:0]  addr_i;
   logic        we_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        dp_in_valid_o;
   logic [31:0] dp_in_data_o;
   logic        dp_in_ready_i = 1'b1;
   logic        dp_out_valid_i = 1'b0;
   logic [31:0] dp_out_data_i = '0;
   logic        dp_out_ready_o;
   logic        irq_o;

   int n_cmp = 0;
   int n_err = 0;
   int irq_cnt = 0;
   int rdy_mode = 0;
   logic hold = 1'b0;

   bitrev_seq #(.DW(32), .Depth(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
      .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .dp_in_valid_o(dp_in_valid_o), .dp_in_data_o(dp_in_data_o),
      .dp_in_ready_i(dp_in_ready_i), .dp_out_valid_i(dp_out_valid_i),
      .dp_out_data_i(dp_out_data_i), .dp_out_ready_o(dp_out_ready_o),
      .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] rev32(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = x[31-i];
      return r;
   endfunction

   // handshakes are sampled mid-cycle and committed at the next edge
   logic        s_in_hs = 1'b0;
   logic        s_out_hs = 1'b0;
   logic [31:0] s_in_word = '0;
   always @(negedge clk_i) begin
      s_in_hs   = dp_in_valid_o && dp_in_ready_i;
      s_out_hs  = dp_out_valid_i && dp_out_ready_o;
      s_in_word = dp_in_data_o;
   end

   logic [31:0] q_data[$];
   int          q_time[$];
   int          m_cyc = 0;
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_data.delete();
         q_time.delete();
         dp_out_valid_i = 1'b0;
         dp_out_data_i  = '0;
         m_cyc = 0;
      end else begin
         #1;
         m_cyc++;
         if (s_out_hs && q_data.size() > 0) begin
            void'(q_data.pop_front());
            void'(q_time.pop_front());
         end
         if (s_in_hs) begin
            q_data.push_back(rev32(s_in_word));
            q_time.push_back(m_cyc + 1);
         end
         case (rdy_mode)
            0:       dp_in_ready_i = 1'b1;
            1:       dp_in_ready_i = ~dp_in_ready_i;
            default: dp_in_ready_i = 1'b0;
         endcase
         if (!hold && q_data.size() > 0 && q_time[0] <= m_cyc) begin
            dp_out_valid_i = 1'b1;
            dp_out_data_i  = q_data[0];
         end else begin
            dp_out_valid_i = 1'b0;
            dp_out_data_i  = '0;
         end
      end
   end

   always @(posedge clk_i) begin
      #1;
      if (irq_o === 1'b1) irq_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   task automatic acc(input logic [4:0] a, input logic w,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic er);
      req_i = 1'b1; addr_i = a; we_i = w; wdata_i = d;
      @(posedge clk_i);
      #2;
      req_i = 1'b0; we_i = 1'b0; wdata_i = '0;
      chk("rvalid", 32'(rvalid_o), 32'd1);
      rd = rdata_o;
      er = err_o;
   endtask

   task automatic wr(input string tag, input logic [4:0] a,
                     input logic [31:0] d, input logic exp_err);
      logic [31:0] rd;
      logic er;
      acc(a, 1'b1, d, rd, er);
      chk({tag, ".err"}, 32'(er), 32'(exp_err));
   endtask

   task automatic rd(input string tag, input logic [4:0] a,
                     input logic [31:0] exp, input logic exp_err);
      logic [31:0] d;
      logic er;
      acc(a, 1'b0, '0, d, er);
      chk({tag, ".data"}, d, exp);
      chk({tag, ".err"}, 32'(er), 32'(exp_err));
   endtask

   task automatic wait_idle(input string tag, input int max);
      logic [31:0] d;
      logic er;
      d = 32'd1;
      for (int i = 0; i < max; i++) begin
         acc(5'h04, 1'b0, '0, d, er);
         if (d[0] == 1'b0) break;
      end
      chk({tag, ".idle"}, 32'(d[0]), 32'd0);
   endtask

   initial begin
      rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wdata_i = '0;
      @(posedge clk_i);
      #2;
      chk("rst.gnt", 32'(gnt_o), 32'd1);
      chk("rst.rvalid", 32'(rvalid_o), 32'd0);
      chk("rst.dpin_v", 32'(dp_in_valid_o), 32'd0);
      chk("rst.dpout_r", 32'(dp_out_ready_o), 32'd0);
      chk("rst.irq", 32'(irq_o), 32'd0);
      rst_i = 1'b0;
      idle(1);
      rd("rst.status", 5'h04, 32'h0, 1'b0);
      rd("ctrl.read", 5'h00, 32'h0, 1'b1);
      wr("stat.write", 5'h04, 32'h1, 1'b1);
      rd("unmapped", 5'h1C, 32'h0, 1'b1);

      // basic job
      wr("b.len", 5'h10, 32'd3, 1'b0);
      wr("b.din0", 5'h08, 32'h1, 1'b0);
      wr("b.din1", 5'h08, 32'h2, 1'b0);
      wr("b.din2", 5'h08, 32'h4, 1'b0);
      rd("b.stat0", 5'h04, 32'h0000_0300, 1'b0);
      wr("b.start", 5'h00, 32'h1, 1'b0);
      wait_idle("b", 60);
      rd("b.stat1", 5'h04, 32'h0003_0002, 1'b0);
      chk("b.irq", irq_cnt, 1);
      rd("b.dout0", 5'h0C, 32'h8000_0000, 1'b0);
      rd("b.dout1", 5'h0C, 32'h4000_0000, 1'b0);
      rd("b.dout2", 5'h0C, 32'h2000_0000, 1'b0);
      rd("b.dout3", 5'h0C, 32'h0, 1'b1);

      // backpressure
      wr("p.len", 5'h10, 32'd6, 1'b0);
      wr("p.din0", 5'h08, 32'h0000_0003, 1'b0);
      wr("p.din1", 5'h08, 32'h0000_0005, 1'b0);
      wr("p.din2", 5'h08, 32'h0000_0010, 1'b0);
      wr("p.din3", 5'h08, 32'h0000_00FF, 1'b0);
      rdy_mode = 1;
      wr("p.start", 5'h00, 32'h1, 1'b0);
      idle(10);
      wr("p.din4", 5'h08, 32'h1234_5678, 1'b0);
      wr("p.din5", 5'h08, 32'h8000_0001, 1'b0);
      idle(30);
      chk("p.dpout_r", 32'(dp_out_ready_o), 32'd0);
      rd("p.stat0", 5'h04, 32'h0004_0001, 1'b0);
      rd("p.dout0", 5'h0C, 32'hC000_0000, 1'b0);
      rd("p.dout1", 5'h0C, 32'hA000_0000, 1'b0);
      wait_idle("p", 40);
      rd("p.stat1", 5'h04, 32'h0004_0002, 1'b0);
      chk("p.irq", irq_cnt, 2);
      rd("p.dout2", 5'h0C, 32'h0800_0000, 1'b0);
      rd("p.dout3", 5'h0C, 32'hFF00_0000, 1'b0);
      rd("p.dout4", 5'h0C, 32'h1E6A_2C48, 1'b0);
      rd("p.dout5", 5'h0C, 32'h8000_0001, 1'b0);
      rdy_mode = 0;

      // overflow
      wr("o.din0", 5'h08, 32'h11, 1'b0);
      wr("o.din1", 5'h08, 32'h12, 1'b0);
      wr("o.din2", 5'h08, 32'h13, 1'b0);
      wr("o.din3", 5'h08, 32'h14, 1'b0);
      wr("o.din4", 5'h08, 32'h15, 1'b1);
      rd("o.stat", 5'h04, 32'h0000_0402, 1'b0);
      wr("o.clear", 5'h00, 32'h2, 1'b0);
      rd("o.stat1", 5'h04, 32'h0, 1'b0);

      // abort during drain
      wr("a.len", 5'h10, 32'd2, 1'b0);
      wr("a.din0", 5'h08, 32'h1, 1'b0);
      wr("a.din1", 5'h08, 32'h2, 1'b0);
      hold = 1'b1;
      wr("a.start", 5'h00, 32'h1, 1'b0);
      idle(8);
      rd("a.stat0", 5'h04, 32'h0000_0001, 1'b0);
      wr("a.clear", 5'h00, 32'h2, 1'b0);
      chk("a.flush_r", 32'(dp_out_ready_o), 32'd1);
      rd("a.stat1", 5'h04, 32'h0000_0001, 1'b0);
      hold = 1'b0;
      wait_idle("a", 30);
      rd("a.stat2", 5'h04, 32'h0, 1'b0);
      chk("a.irq", irq_cnt, 2);
      rd("a.dout", 5'h0C, 32'h0, 1'b1);

      // illegal starts
      wr("i.len0", 5'h10, 32'd0, 1'b0);
      wr("i.start0", 5'h00, 32'h1, 1'b0);
      rd("i.stat0", 5'h04, 32'h0, 1'b0);
      wr("i.len1", 5'h10, 32'd1, 1'b0);
      wr("i.both", 5'h00, 32'h3, 1'b0);
      rd("i.stat1", 5'h04, 32'h0, 1'b0);
      wr("i.din", 5'h08, 32'h1, 1'b0);
      hold = 1'b1;
      wr("i.start", 5'h00, 32'h1, 1'b0);
      idle(3);
      rd("i.stat2", 5'h04, 32'h0000_0001, 1'b0);
      wr("i.lenbusy", 5'h10, 32'd9, 1'b1);
      rd("i.len", 5'h10, 32'd1, 1'b0);
      hold = 1'b0;
      wait_idle("i", 30);
      rd("i.stat3", 5'h04, 32'h0001_0002, 1'b0);
      chk("i.irq", irq_cnt, 3);
      rd("i.dout", 5'h0C, 32'h8000_0000, 1'b0);

      // async reset mid-run
      wr("r.len", 5'h10, 32'd2, 1'b0);
      wr("r.din", 5'h08, 32'hA5, 1'b0);
      rdy_mode = 2;
      wr("r.start", 5'h00, 32'h1, 1'b0);
      idle(3);
      chk("r.dpin_v", 32'(dp_in_valid_o), 32'd1);
      chk("r.dpin_d", dp_in_data_o, 32'hA5);
      chk("r.dpout_r", 32'(dp_out_ready_o), 32'd1);
      #1;
      rst_i = 1'b1;
      #1;
      chk("r.rst_v", 32'(dp_in_valid_o), 32'd0);
      chk("r.rst_d", dp_in_data_o, 32'h0);
      chk("r.rst_r", 32'(dp_out_ready_o), 32'd0);
      chk("r.rst_rv", 32'(rvalid_o), 32'd0);
      chk("r.rst_rd", rdata_o, 32'h0);
      chk("r.rst_irq", 32'(irq_o), 32'd0);
      chk("r.rst_gnt", 32'(gnt_o), 32'd1);
      #2;
      rst_i = 1'b0;
      rdy_mode = 0;
      @(posedge clk_i);
      #2;
      rd("r.stat", 5'h04, 32'h0, 1'b0);
      rd("r.len0", 5'h10, 32'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
